// File: rtl/fpu_addsub_scheduler.sv
// rtl/fpu_addsub_scheduler.sv - two-requester scheduler for a shared pipelined FP add/sub unit
// Optional feature macro: FPU_SCHED_STATS_EN adds saturating issue counters stat_issue0/stat_issue1.

module fpu_addsub_scheduler #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_op,
  input  logic [31:0] fpu_result,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
`ifdef FPU_SCHED_STATS_EN
  output logic        busy,
  output logic [15:0] stat_issue0,
  output logic [15:0] stat_issue1
`else
  output logic        busy
`endif
);

  localparam int RSP_DEPTH = LATENCY + 1;
  localparam int PW        = $clog2(RSP_DEPTH);
  localparam int CW        = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

  logic [LATENCY-1:0] pipe_v;
  logic [LATENCY-1:0] pipe_id;
  logic               rr_next;
  logic               elig0, elig1, grant0, grant1, issue;
  logic [1:0]         issued, push, pop, rsp_valid_v, rsp_ready_v;
  logic [CW-1:0]      outstanding_v [2];
  logic [31:0]        rsp_data_v [2];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Grant selection: at full credit the FIFO is guaranteed to hold a result, so rspN_ready
  // alone stands in for the pop and the ready path never depends on rspN_valid.
  always_comb begin
    elig0  = !rst && req0_valid &&
             ((outstanding_v[0] < DEPTH_C) || (outstanding_v[0] == DEPTH_C && rsp0_ready));
    elig1  = !rst && req1_valid &&
             ((outstanding_v[1] < DEPTH_C) || (outstanding_v[1] == DEPTH_C && rsp1_ready));
    grant0 = elig0 && (!elig1 || !rr_next);
    grant1 = elig1 && (!elig0 || rr_next);
    issue  = grant0 || grant1;
    fpu_a  = '0;
    fpu_b  = '0;
    fpu_op = 1'b0;
    if (grant0) begin
      fpu_a  = req0_a;
      fpu_b  = req0_b;
      fpu_op = req0_op;
    end else if (grant1) begin
      fpu_a  = req1_a;
      fpu_b  = req1_b;
      fpu_op = req1_op;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign issued      = {grant1, grant0};
  assign push        = {pipe_v[LATENCY-1] && pipe_id[LATENCY-1],
                        pipe_v[LATENCY-1] && !pipe_id[LATENCY-1]};
  assign rsp_ready_v = {rsp1_ready, rsp0_ready};
  assign pop         = rsp_valid_v & rsp_ready_v;
  assign rsp0_valid  = rsp_valid_v[0];
  assign rsp1_valid  = rsp_valid_v[1];
  assign rsp0_data   = rsp_data_v[0];
  assign rsp1_data   = rsp_data_v[1];
  assign busy        = (outstanding_v[0] != '0) || (outstanding_v[1] != '0);

  // Issue-tracking shift pipeline and round-robin pointer (points at the next tie winner)
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v  <= '0;
      pipe_id <= '0;
      rr_next <= 1'b0;
    end else begin
      pipe_v  <= LATENCY'({pipe_v, issue});
      pipe_id <= LATENCY'({pipe_id, grant1});
      if (issue) rr_next <= grant0;
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_rsp
    logic [31:0]   mem [RSP_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, outstanding;

    // Response FIFO capturing the adder result as the tracked issue leaves the pipeline,
    // plus the credit counter covering in-flight and FIFO-held results
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        cnt         <= '0;
        outstanding <= '0;
      end else begin
        if (push[n]) begin
          mem[wr_ptr] <= fpu_result;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop[n]) rd_ptr <= ptr_inc(rd_ptr);
        case ({push[n], pop[n]})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
        case ({issued[n], pop[n]})
          2'b10:   outstanding <= outstanding + CW'(1);
          2'b01:   outstanding <= outstanding - CW'(1);
          default: outstanding <= outstanding;
        endcase
      end
    end

    assign rsp_valid_v[n]   = (cnt != '0);
    assign rsp_data_v[n]    = rsp_valid_v[n] ? mem[rd_ptr] : '0;
    assign outstanding_v[n] = outstanding;
  end

`ifdef FPU_SCHED_STATS_EN
  // Saturating per-requester handshake counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue0 <= '0;
      stat_issue1 <= '0;
    end else begin
      if (grant0 && stat_issue0 != 16'hFFFF) stat_issue0 <= stat_issue0 + 16'd1;
      if (grant1 && stat_issue1 != 16'hFFFF) stat_issue1 <= stat_issue1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_addsub_scheduler.sv
// tb/tb_fpu_addsub_scheduler.sv - scoreboard bench for fpu_addsub_scheduler
module tb_fpu_addsub_scheduler;

  localparam int LAT   = 1;
  localparam int DEPTH = LAT + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req0_ready, req0_op, req1_valid, req1_ready, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] fpu_a, fpu_b, fpu_result;
  logic        fpu_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;
  logic [31:0] rsp0_data, rsp1_data;
`ifdef FPU_SCHED_STATS_EN
  logic [15:0] stat_issue0, stat_issue1;
`endif

  // Hand-computed single-precision vectors: a op b = r
  localparam logic [31:0] VA [8] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40800000,
                                     32'h40A00000, 32'h40C00000, 32'h3F000000, 32'h41200000};
  localparam logic [31:0] VB [8] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h40000000,
                                     32'h3F800000, 32'h40A00000, 32'h3F000000, 32'h40A00000};
  localparam logic        VO [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [31:0] VR [8] = '{32'h40400000, 32'h40000000, 32'h40800000, 32'h40000000,
                                     32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h41700000};

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          src0[$], src1[$];
  logic [31:0] exp0[$], exp1[$];
  int          hs_id[$], hs_cyc[$];
  int          hs0_n = 0, hs1_n = 0;
  logic        rr0_ctl = 1'b1, rr1_ctl = 1'b1;

  fpu_addsub_scheduler #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_result(fpu_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
`ifdef FPU_SCHED_STATS_EN
    .busy(busy), .stat_issue0(stat_issue0), .stat_issue1(stat_issue1)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    for (int i = 0; i < 8; i++)
      if (VA[i] == a && VB[i] == b && VO[i] == op) return VR[i];
    return 32'hDEADBEEF;
  endfunction

  // One-cycle registered adder
  always @(posedge clk) fpu_result <= adder_model(fpu_a, fpu_b, fpu_op);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Driver: presents queued requests mid-cycle, logs handshakes and pushes expected results
  initial begin
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    forever begin
      @(negedge clk);
      req0_valid = (src0.size() > 0);
      req1_valid = (src1.size() > 0);
      req0_a  = req0_valid ? VA[src0[0]] : 32'h0;
      req0_b  = req0_valid ? VB[src0[0]] : 32'h0;
      req0_op = req0_valid ? VO[src0[0]] : 1'b0;
      req1_a  = req1_valid ? VA[src1[0]] : 32'h0;
      req1_b  = req1_valid ? VB[src1[0]] : 32'h0;
      req1_op = req1_valid ? VO[src1[0]] : 1'b0;
      rsp0_ready = rr0_ctl;
      rsp1_ready = rr1_ctl;
      #4;
      if (req0_valid && req0_ready) begin
        exp0.push_back(VR[src0[0]]);
        void'(src0.pop_front());
        hs_id.push_back(0); hs_cyc.push_back(cyc); hs0_n++;
      end
      if (req1_valid && req1_ready) begin
        exp1.push_back(VR[src1[0]]);
        void'(src1.pop_front());
        hs_id.push_back(1); hs_cyc.push_back(cyc); hs1_n++;
      end
    end
  end

  // Monitor: pops scoreboard on every response pop, checks head stability and credit bound
  initial begin
    int   o0, o1;
    logic hold0, hold1;
    logic [31:0] held0, held1;
    o0 = 0; o1 = 0; hold0 = 0; hold1 = 0; held0 = 0; held1 = 0;
    forever begin
      @(negedge clk); #4;
      if (rst) begin
        o0 = 0; o1 = 0; hold0 = 0; hold1 = 0;
      end else begin
        check("one_issue_per_cycle", 32'(req0_valid && req0_ready && req1_valid && req1_ready), 0);
        if (rsp0_valid && rsp0_ready) begin
          if (exp0.size() == 0) check("rsp0_unexpected", 32'(rsp0_valid), 0);
          else check("rsp0_data", rsp0_data, exp0.pop_front());
        end
        if (rsp1_valid && rsp1_ready) begin
          if (exp1.size() == 0) check("rsp1_unexpected", 32'(rsp1_valid), 0);
          else check("rsp1_data", rsp1_data, exp1.pop_front());
        end
        if (hold0) check("rsp0_hold_stable", rsp0_data, held0);
        if (hold1) check("rsp1_hold_stable", rsp1_data, held1);
        hold0 = rsp0_valid && !rsp0_ready; held0 = rsp0_data;
        hold1 = rsp1_valid && !rsp1_ready; held1 = rsp1_data;
        o0 = o0 + int'(req0_valid && req0_ready) - int'(rsp0_valid && rsp0_ready);
        o1 = o1 + int'(req1_valid && req1_ready) - int'(rsp1_valid && rsp1_ready);
        if (o0 > DEPTH || o1 > DEPTH) check("credit_overflow", 32'(o0 > DEPTH || o1 > DEPTH), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #4;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((src0.size() > 0 || src1.size() > 0 || exp0.size() > 0 || exp1.size() > 0 || busy) && k < budget) begin
      tick(); k++;
    end
    check("drain_in_budget", 32'(k < budget), 1);
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int k = 0;
    while (hs_id.size() < target && k < budget) begin
      tick(); k++;
    end
    check(name, 32'(hs_id.size() >= target), 1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base, h0, h1;
    logic seen;
    logic [7:0] pat;

    // Reset state, with a request already waiting
    rst = 1;
    repeat (2) tick();
    src0.push_back(0);
    sample();
    check("rst_req0_ready", 32'(req0_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fpu_a", fpu_a, 0);
    check("rst_fpu_b", fpu_b, 0);
    check("rst_fpu_op", 32'(fpu_op), 0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 0);
    check("rst_rsp0_data", rsp0_data, 0);

    // Single add: 1.0 + 2.0, response two cycles after the handshake
    tick(); rst = 0;
    sample();
    check("add_handshake", 32'(req0_ready), 1);
    check("add_fpu_a", fpu_a, 32'h3F800000);
    sample();
    check("add_rsp_T+1", 32'(rsp0_valid), 0);
    sample();
    check("add_rsp_T+2", 32'(rsp0_valid), 1);
    check("add_rsp_data", rsp0_data, 32'h40400000);
    drain(20);

    // Subtract on req1: 3.0 - 1.0, req0 side stays quiet
    tick(); src1.push_back(1);
    seen = 0;
    repeat (6) begin sample(); if (rsp0_valid) seen = 1; end
    check("sub_rsp0_quiet", 32'(seen), 0);
    drain(20);

    // Contention: strict alternation starting with req0, one issue per cycle
    tick();
    base = hs_id.size();
    src0.push_back(2); src0.push_back(4); src0.push_back(6); src0.push_back(7);
    src1.push_back(3); src1.push_back(5); src1.push_back(0); src1.push_back(1);
    wait_hs(base + 8, 30, "rr_handshakes_done");
    if (hs_id.size() >= base + 8) begin
      pat = 0;
      for (int i = 0; i < 8; i++) pat[i] = hs_id[base + i][0];
      check("rr_order", 32'(pat), 32'hAA);
      check("rr_span", 32'(hs_cyc[base + 7] - hs_cyc[base]), 7);
    end
    drain(30);

    // Backpressure on rsp0: two req0 credits, req1 keeps flowing
    tick();
    rr0_ctl = 0;
    base = hs_id.size(); h0 = hs0_n; h1 = hs1_n;
    src0.push_back(0); src0.push_back(2); src0.push_back(4); src0.push_back(6); src0.push_back(7);
    src1.push_back(1); src1.push_back(3); src1.push_back(5); src1.push_back(0);
    repeat (10) tick();
    check("bp_req0_hs", 32'(hs0_n - h0), 2);
    check("bp_req1_hs", 32'(hs1_n - h1), 4);
    if (hs_cyc.size() >= base + 6) check("bp_span", 32'(hs_cyc[hs_cyc.size() - 1] - hs_cyc[base]), 5);
    sample();
    check("bp_req0_blocked", 32'(req0_ready), 0);
    tick(); rr0_ctl = 1;
    sample();
    check("bp_pulse_pop", 32'(rsp0_valid && rsp0_ready), 1);
    check("bp_pulse_hs", 32'(req0_ready), 1);
    tick(); rr0_ctl = 0;
    sample();
    check("bp_after_pulse", 32'(req0_ready), 0);
    tick();
    check("bp_req0_hs_total", 32'(hs0_n - h0), 3);
    rr0_ctl = 1;
    drain(40);

    // Reset one cycle after a handshake: result discarded, pointer back to req0
    tick(); src0.push_back(2);
    sample();
    check("rif_handshake", 32'(req0_ready), 1);
    tick(); rst = 1;
    sample();
    check("rif_ready_in_rst", 32'(req0_ready), 0);
    tick(); rst = 0;
    exp0.delete(); exp1.delete();
    sample();
    check("rif_busy", 32'(busy), 0);
    seen = 0;
    repeat (6) begin sample(); if (rsp0_valid) seen = 1; end
    check("rif_no_rsp", 32'(seen), 0);
    tick();
    base = hs_id.size();
    src0.push_back(4); src1.push_back(5);
    wait_hs(base + 2, 10, "rif_tie_done");
    if (hs_id.size() >= base + 2) check("rif_tie_req0", 32'(hs_id[base]), 0);
    drain(20);

`ifdef FPU_SCHED_STATS_EN
    tick(); rst = 1; tick(); rst = 0;
    src0.push_back(0); src0.push_back(0); src0.push_back(0);
    src1.push_back(1); src1.push_back(1);
    drain(30);
    check("stat_issue0", 32'(stat_issue0), 3);
    check("stat_issue1", 32'(stat_issue1), 2);
    for (int i = 0; i < 70000; i++) src0.push_back(0);
    drain(80000);
    check("stat_issue0_sat", 32'(stat_issue0), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_scheduler.md
FPU_ADDSUB_SCHEDULER -- requirements
Module: fpu_addsub_scheduler

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning the adder cycles from operand sample to valid fpu_result (legal 1..4).
REQ-002 SHALL derive localparam RSP_DEPTH = LATENCY+1, the per-requester response FIFO depth.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 reqN_valid  in  1  request present, for N in {0,1}.
REQ-006 reqN_ready  out  1  scheduler accepts reqN this cycle.
REQ-007 reqN_a, reqN_b  in  32  IEEE-754 single operands.
REQ-008 reqN_op  in  1  0 = add, 1 = subtract.
REQ-009 fpu_a, fpu_b  out  32  operands to the shared adder.
REQ-010 fpu_op  out  1  operation to the shared adder.
REQ-011 fpu_result  in  32  adder result.
REQ-012 rspN_valid  out  1  response available to requester N.
REQ-013 rspN_ready  in  1  requester N consumes the response.
REQ-014 rspN_data  out  32  result returned to requester N.
REQ-015 busy  out  1  any operation in flight or any response FIFO non-empty.

Function
REQ-016 SHALL issue at most one operation per cycle; a handshake is reqN_valid && reqN_ready in the same cycle.
REQ-017 Requester N is eligible when reqN_valid=1 and (outstanding_N < RSP_DEPTH, or outstanding_N == RSP_DEPTH with rspN pop this cycle).
- outstanding_N counts in-flight plus FIFO-held results for N.
REQ-018 One eligible requester: grant it.
REQ-019 Both eligible: grant the requester not granted last (round-robin).
- Pointer updates only on a grant.
- After reset, req0 wins the first tie.
REQ-020 reqN_ready SHALL be 1 only for the granted requester; it depends combinationally on reqN_valid and rspN_ready, never on rspN_valid.
REQ-021 SHALL drive fpu_a/fpu_b/fpu_op from the granted requester combinationally; with no grant, drive all zeros.
REQ-022 SHALL track each issue in a LATENCY-stage valid+requester-id shift pipeline.
REQ-023 For an issue in cycle T, SHALL capture fpu_result at the end of cycle T+LATENCY into FIFO N; earliest rspN_valid is cycle T+LATENCY+1.
REQ-024 SHALL update outstanding_N each cycle by +1 on issue to N and -1 on rspN pop; a simultaneous issue and pop leaves it unchanged.
REQ-025 Response FIFOs SHALL preserve per-requester issue order; rspN_data is the FIFO head and is stable while rspN_valid && !rspN_ready.
REQ-026 The credit rule SHALL guarantee the FIFOs never overflow; a write to a full FIFO is a design error and is flagged by a bench assertion.
REQ-027 Pointers and counters SHALL wrap modulo RSP_DEPTH.
- Simultaneous push and pop on a full FIFO is legal.
- Simultaneous push and pop on an empty FIFO bypasses nothing: rspN_valid rises the next cycle.

Reset
REQ-028 While rst=1 at a clock edge, SHALL clear pipeline valids, FIFOs, outstanding counters and the round-robin pointer.
- Outputs read rspN_valid=0, reqN_ready=0, busy=0, fpu_a/fpu_b/fpu_op=0, rspN_data=0.
REQ-029 Reset mid-operation SHALL discard every in-flight result; no response for any pre-reset request appears afterwards.
REQ-030 reqN_ready SHALL be 0 during any cycle in which rst=1.

Configuration
REQ-031 Macro FPU_SCHED_STATS_EN: when defined, SHALL add outputs stat_issue0 and stat_issue1 (out, 16 bits).
- Each counts handshakes for that requester and saturates at 0xFFFF.
- Both are cleared by rst.
REQ-032 Without FPU_SCHED_STATS_EN, those ports and counters SHALL NOT exist; all other behaviour is identical.

Verification (bench uses the team's 1-cycle-registered adder, LATENCY=1)
REQ-033 Single add: req0 sends 0x3F800000 + 0x40000000, op=0, handshake at T -> rsp0_valid at T+2 with rsp0_data=0x40400000.
REQ-034 Subtract: req1 sends 0x40400000 - 0x3F800000, op=1 -> rsp1_data=0x40000000, with rsp0_valid remaining 0.
REQ-035 Contention: both requesters valid every cycle, both rspN_ready=1 -> grants alternate 0,1,0,1 starting with req0, one issue per cycle.
REQ-036 Backpressure: rsp0_ready=0, req0 valid continuously -> exactly 2 req0 handshakes then req0_ready=0, while req1 is still served every cycle it is valid.
- Raising rsp0_ready for one cycle -> one pop and one new req0 handshake in that same cycle.
REQ-037 Reset in flight: rst=1 in cycle T+1 after a handshake at T -> no rsp0_valid ever follows, busy=0 after the reset edge, and the next tie grants req0.
REQ-038 With FPU_SCHED_STATS_EN: 3 req0 and 2 req1 handshakes -> stat_issue0=3, stat_issue1=2; 70000 req0 handshakes -> stat_issue0=0xFFFF.
